// File: rtl/tlul_seq_host_if.sv
// Minimal TL-UL type package plus the host-side bus interface for tlul_seq_host.
// Optional build macro consumed by the engine: TLUL_SEQ_HOST_INTG_EN.
package tlul_pkg;
  typedef enum logic [2:0] {PutFullData = 3'h0, PutPartialData = 3'h1, Get = 3'h4} tl_a_op_e;
  typedef enum logic [2:0] {AccessAck = 3'h0, AccessAckData = 3'h1} tl_d_op_e;

  typedef struct packed {
    logic [3:0] instr_type;
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  parameter tl_a_user_t TL_A_USER_DEFAULT = '{instr_type: 4'h9, cmd_intg: 7'h0, data_intg: 7'h0};

  typedef struct packed {
    logic        a_valid;
    tl_a_op_e    a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    tl_d_op_e    d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    tl_d_user_t  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

interface tlul_seq_host_if;
  import tlul_pkg::*;
  tl_h2d_t tl_o;
  tl_d2h_t tl_i;
  modport master (output tl_o, input tl_i);
  modport slave  (input tl_o, output tl_i);
endinterface

// File: rtl/tlul_seq_host.sv
// Sequential TL-UL host: bursts Get/PutFullData over a word range with bounded outstanding.
// Define TLUL_SEQ_HOST_INTG_EN to generate a_user integrity and check D-channel integrity.
module tlul_seq_host
  import tlul_pkg::*;
#(
  parameter int MaxOutstanding = 2,
  parameter int CntW           = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            op_we_i,
  input  logic [31:0]     base_addr_i,
  input  logic [CntW-1:0] num_words_i,
  input  logic [31:0]     wdata_i,
  input  logic            wvalid_i,
  output logic            wready_o,
  output logic [31:0]     rdata_o,
  output logic            rvalid_o,
  input  logic            rready_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  tlul_seq_host_if.master tl
);
  localparam int OutW = $clog2(MaxOutstanding + 1);
  localparam int SrcW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_e;

  state_e          state_q;
  logic            we_q, busy_q, done_q, err_q;
  logic [31:0]     addr_q;
  logic [CntW-1:0] cnt_q, issued_q, completed_q;
  logic [OutW-1:0] outst_q;
  logic [SrcW-1:0] a_src_q, d_src_q;

  logic    a_valid, a_fire, d_ready, d_fire, d_bad, intg_err;
  tl_h2d_t h2d;

  // a_valid never looks at a_ready; outstanding only drops, so once raised it holds until fire
  assign a_valid = (state_q == ISSUE) && (issued_q < cnt_q) &&
                   (outst_q < OutW'(MaxOutstanding)) && (!we_q || wvalid_i);
  assign a_fire  = a_valid && tl.tl_i.a_ready;
  assign d_ready = busy_q && (we_q || rready_i);
  assign d_fire  = tl.tl_i.d_valid && d_ready;
  assign d_bad   = tl.tl_i.d_error || intg_err ||
                   (tl.tl_i.d_opcode != (we_q ? AccessAck : AccessAckData)) ||
                   (tl.tl_i.d_source != 8'(d_src_q));

  always_comb begin
    h2d           = '0;
    h2d.a_valid   = a_valid;
    h2d.a_opcode  = we_q ? PutFullData : Get;
    h2d.a_param   = 3'd0;
    h2d.a_size    = 2'd2;
    h2d.a_source  = 8'(a_src_q);
    h2d.a_address = addr_q;
    h2d.a_mask    = 4'hF;
    h2d.a_data    = we_q ? wdata_i : 32'h0;
    h2d.a_user    = TL_A_USER_DEFAULT;
    h2d.d_ready   = d_ready;
  end

`ifdef TLUL_SEQ_HOST_INTG_EN
  tlul_cmd_intg_gen u_cmd_intg (.tl_i(h2d), .tl_o(tl.tl_o));
  tlul_rsp_intg_chk u_rsp_intg (.tl_i(tl.tl_i), .err_o(intg_err));
`else
  assign tl.tl_o   = h2d;
  assign intg_err  = 1'b0;
`endif

  assign wready_o = we_q && a_fire;
  assign rvalid_o = busy_q && !we_q && tl.tl_i.d_valid;
  assign rdata_o  = (busy_q && !we_q) ? tl.tl_i.d_data : 32'h0;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign err_o    = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
      issued_q    <= '0;
      completed_q <= '0;
      outst_q     <= '0;
      a_src_q     <= '0;
      d_src_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (a_fire) begin
        issued_q <= issued_q + CntW'(1);
        addr_q   <= addr_q + 32'd4;
        a_src_q  <= (a_src_q == SrcW'(MaxOutstanding - 1)) ? '0 : a_src_q + SrcW'(1);
      end
      if (d_fire) begin
        completed_q <= completed_q + CntW'(1);
        d_src_q     <= (d_src_q == SrcW'(MaxOutstanding - 1)) ? '0 : d_src_q + SrcW'(1);
        if (d_bad) err_q <= 1'b1;
      end
      if (a_fire && !d_fire)      outst_q <= outst_q + OutW'(1);
      else if (!a_fire && d_fire) outst_q <= outst_q - OutW'(1);

      case (state_q)
        IDLE: if (start_i) begin
          we_q        <= op_we_i;
          addr_q      <= base_addr_i & ~32'h3;
          cnt_q       <= num_words_i;
          issued_q    <= '0;
          completed_q <= '0;
          outst_q     <= '0;
          a_src_q     <= '0;
          d_src_q     <= '0;
          err_q       <= 1'b0;
          if (num_words_i == '0) begin
            state_q <= FIN;
          end else begin
            state_q <= ISSUE;
            busy_q  <= 1'b1;
          end
        end
        ISSUE: if (a_fire && (issued_q + CntW'(1) == cnt_q)) state_q <= DRAIN;
        DRAIN: if (d_fire && (completed_q + CntW'(1) == cnt_q)) begin
          state_q <= FIN;
          busy_q  <= 1'b0;
        end
        FIN: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
